// File: rtl/z80_bus_iface.sv
// z80_bus_iface: registered boundary between the Z80 core and the pad ring.
//   - Core-to-pad address, data and strobes are registered (1-cycle latency),
//     and the active-high core strobes become active-low pad strobes.
//   - INT/NMI/WAIT pads pass through SYNC_STAGES-deep synchronisers.
//   - NMI falling edges are filtered (NMI_FILTER low samples) and latched
//     in CORE_NMI_PEND until the core acknowledges them.
//   - DOE_PAD is gated so that at least TURNAROUND idle cycles separate
//     consecutive data-bus drive windows.
//   - Read data is captured from DI_PAD only while the block is not driving.
// Ports:
//   CLK, RESET (async, active-low)
//   pad side : DI_PAD, INT_PAD, NMI_PAD, WAIT_PAD in; DO_PAD, DOE_PAD,
//              ADDR_PAD, WR/MREQ/IORQ/M1/HALT_PAD out
//   core side: CORE_DO, CORE_ADDR, CORE_WR/MREQ/IORQ/M1/HALT, CORE_NMI_ACK in;
//              CORE_DI, CORE_INT, CORE_WAIT, CORE_NMI_PEND out
module z80_bus_iface #(
  parameter int DW          = 8,
  parameter int AW          = 16,
  parameter int SYNC_STAGES = 2,
  parameter int NMI_FILTER  = 2,
  parameter int TURNAROUND  = 1
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [DW-1:0] DI_PAD,
  input  logic          INT_PAD,
  input  logic          NMI_PAD,
  input  logic          WAIT_PAD,
  output logic [DW-1:0] DO_PAD,
  output logic          DOE_PAD,
  output logic [AW-1:0] ADDR_PAD,
  output logic          WR_PAD,
  output logic          MREQ_PAD,
  output logic          IORQ_PAD,
  output logic          M1_PAD,
  output logic          HALT_PAD,
  input  logic [DW-1:0] CORE_DO,
  input  logic [AW-1:0] CORE_ADDR,
  input  logic          CORE_WR,
  input  logic          CORE_MREQ,
  input  logic          CORE_IORQ,
  input  logic          CORE_M1,
  input  logic          CORE_HALT,
  input  logic          CORE_NMI_ACK,
  output logic [DW-1:0] CORE_DI,
  output logic          CORE_INT,
  output logic          CORE_WAIT,
  output logic          CORE_NMI_PEND
);

  localparam int CMAX = (NMI_FILTER > TURNAROUND) ? NMI_FILTER : TURNAROUND;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] FILT_C = CW'(NMI_FILTER);
  localparam logic [CW-1:0] TA_C   = CW'(TURNAROUND);

  // strobe vector order: {HALT, M1, IORQ, MREQ, WR}
  logic [AW-1:0]          addr_q, addr_d;
  logic [DW-1:0]          do_q, do_d;
  logic [4:0]             strb_q, strb_d;
  logic                   doe_q, doe_d;
  logic [CW-1:0]          ta_q, ta_d;
  logic [DW-1:0]          di_q, di_d;
  logic [SYNC_STAGES-1:0] int_sync_q, int_sync_d;
  logic [SYNC_STAGES-1:0] wait_sync_q, wait_sync_d;
  logic [SYNC_STAGES-1:0] nmi_sync_q, nmi_sync_d;
  logic [CW-1:0]          nmi_cnt_q, nmi_cnt_d;
  logic                   armed_q, armed_d;
  logic                   pend_q, pend_d;
  logic                   nmi_s, accept;

  assign nmi_s  = nmi_sync_q[SYNC_STAGES-1];
  assign accept = (nmi_cnt_q == FILT_C) && armed_q;

  always_comb begin
    addr_d      = CORE_ADDR;
    do_d        = CORE_DO;
    strb_d      = ~{CORE_HALT, CORE_M1, CORE_IORQ, CORE_MREQ, CORE_WR};
    int_sync_d  = {int_sync_q[SYNC_STAGES-2:0], INT_PAD};
    wait_sync_d = {wait_sync_q[SYNC_STAGES-2:0], WAIT_PAD};
    nmi_sync_d  = {nmi_sync_q[SYNC_STAGES-2:0], NMI_PAD};

    // Never capture our own drive: hold read data while DOE is up.
    di_d = doe_q ? di_q : DI_PAD;

    // Gap counter restarts on every drive cycle and saturates once satisfied.
    if (doe_q)              ta_d = '0;
    else if (ta_q >= TA_C)  ta_d = ta_q;
    else                    ta_d = ta_q + CW'(1);
    doe_d = CORE_WR & (doe_q | (ta_q >= TA_C));

    if (nmi_s)                    nmi_cnt_d = '0;
    else if (nmi_cnt_q == FILT_C) nmi_cnt_d = nmi_cnt_q;
    else                          nmi_cnt_d = nmi_cnt_q + CW'(1);

    // One request per low period: disarm on accept, re-arm once the pin is high.
    if (accept)     armed_d = 1'b0;
    else if (nmi_s) armed_d = 1'b1;
    else            armed_d = armed_q;

    // A fresh accept outranks a simultaneous ack.
    pend_d = accept | (pend_q & ~CORE_NMI_ACK);
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      addr_q      <= '0;
      do_q        <= '0;
      strb_q      <= '1;
      doe_q       <= 1'b0;
      ta_q        <= TA_C;
      di_q        <= '0;
      int_sync_q  <= '1;
      wait_sync_q <= '1;
      nmi_sync_q  <= '1;
      nmi_cnt_q   <= '0;
      armed_q     <= 1'b1;
      pend_q      <= 1'b0;
    end else begin
      addr_q      <= addr_d;
      do_q        <= do_d;
      strb_q      <= strb_d;
      doe_q       <= doe_d;
      ta_q        <= ta_d;
      di_q        <= di_d;
      int_sync_q  <= int_sync_d;
      wait_sync_q <= wait_sync_d;
      nmi_sync_q  <= nmi_sync_d;
      nmi_cnt_q   <= nmi_cnt_d;
      armed_q     <= armed_d;
      pend_q      <= pend_d;
    end
  end

  assign ADDR_PAD      = addr_q;
  assign DO_PAD        = do_q;
  assign DOE_PAD       = doe_q;
  assign WR_PAD        = strb_q[0];
  assign MREQ_PAD      = strb_q[1];
  assign IORQ_PAD      = strb_q[2];
  assign M1_PAD        = strb_q[3];
  assign HALT_PAD      = strb_q[4];
  assign CORE_DI       = di_q;
  assign CORE_INT      = ~int_sync_q[SYNC_STAGES-1];
  assign CORE_WAIT     = ~wait_sync_q[SYNC_STAGES-1];
  assign CORE_NMI_PEND = pend_q;

endmodule

// File: tb/tb_z80_bus_iface.sv
// Scoreboard bench for z80_bus_iface (default parameters).
// Stimulus pushes {cycle, signal, expected} entries; the negedge monitor pops
// every entry due in the current cycle and compares it with the DUT output.
module tb_z80_bus_iface;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  DI_PAD, DO_PAD, CORE_DO, CORE_DI;
  logic        INT_PAD, NMI_PAD, WAIT_PAD, DOE_PAD;
  logic [15:0] ADDR_PAD, CORE_ADDR;
  logic        WR_PAD, MREQ_PAD, IORQ_PAD, M1_PAD, HALT_PAD;
  logic        CORE_WR, CORE_MREQ, CORE_IORQ, CORE_M1, CORE_HALT, CORE_NMI_ACK;
  logic        CORE_INT, CORE_WAIT, CORE_NMI_PEND;

  z80_bus_iface dut (
    .CLK(CLK), .RESET(RESET), .DI_PAD(DI_PAD), .INT_PAD(INT_PAD),
    .NMI_PAD(NMI_PAD), .WAIT_PAD(WAIT_PAD), .DO_PAD(DO_PAD), .DOE_PAD(DOE_PAD),
    .ADDR_PAD(ADDR_PAD), .WR_PAD(WR_PAD), .MREQ_PAD(MREQ_PAD),
    .IORQ_PAD(IORQ_PAD), .M1_PAD(M1_PAD), .HALT_PAD(HALT_PAD),
    .CORE_DO(CORE_DO), .CORE_ADDR(CORE_ADDR), .CORE_WR(CORE_WR),
    .CORE_MREQ(CORE_MREQ), .CORE_IORQ(CORE_IORQ), .CORE_M1(CORE_M1),
    .CORE_HALT(CORE_HALT), .CORE_NMI_ACK(CORE_NMI_ACK), .CORE_DI(CORE_DI),
    .CORE_INT(CORE_INT), .CORE_WAIT(CORE_WAIT), .CORE_NMI_PEND(CORE_NMI_PEND)
  );

  always #5 CLK = ~CLK;

  localparam int S_ADDR = 0, S_DO = 1, S_DOE = 2, S_WR = 3, S_MREQ = 4,
                 S_IORQ = 5, S_M1 = 6, S_HALT = 7, S_DI = 8, S_INT = 9,
                 S_WAIT = 10, S_PEND = 11;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [31:0] get_sig(input int s);
    case (s)
      S_ADDR:  return {16'h0, ADDR_PAD};
      S_DO:    return {24'h0, DO_PAD};
      S_DOE:   return {31'h0, DOE_PAD};
      S_WR:    return {31'h0, WR_PAD};
      S_MREQ:  return {31'h0, MREQ_PAD};
      S_IORQ:  return {31'h0, IORQ_PAD};
      S_M1:    return {31'h0, M1_PAD};
      S_HALT:  return {31'h0, HALT_PAD};
      S_DI:    return {24'h0, CORE_DI};
      S_INT:   return {31'h0, CORE_INT};
      S_WAIT:  return {31'h0, CORE_WAIT};
      default: return {31'h0, CORE_NMI_PEND};
    endcase
  endfunction

  // Monitor: compare every entry that falls due this cycle.
  always @(negedge CLK) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        logic [31:0] act;
        act = get_sig(sb[i].sig);
        checks++;
        if (sb[i].cyc != cyc || act !== sb[i].val) begin
          errors++;
          $display("FAIL %s cyc=%0d actual=%0h expected=%0h", sb[i].name, cyc, act, sb[i].val);
        end
        sb.delete(i);
      end
    end
  end

  // Expect value v on signal s after k more rising edges.
  task automatic expect_at(input int k, input int s, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc = cyc + k; e.sig = s; e.val = v; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b0; DI_PAD = 8'h00; INT_PAD = 1'b1; NMI_PAD = 1'b1; WAIT_PAD = 1'b1;
    CORE_DO = 8'h00; CORE_ADDR = 16'h0000; CORE_WR = 1'b0; CORE_MREQ = 1'b0;
    CORE_IORQ = 1'b0; CORE_M1 = 1'b0; CORE_HALT = 1'b0; CORE_NMI_ACK = 1'b0;
    step(3);
    // reset values while RESET is held low
    expect_at(0, S_ADDR, 0, "rst_addr");  expect_at(0, S_DO, 0, "rst_do");
    expect_at(0, S_DOE, 0, "rst_doe");    expect_at(0, S_WR, 1, "rst_wr");
    expect_at(0, S_MREQ, 1, "rst_mreq");  expect_at(0, S_IORQ, 1, "rst_iorq");
    expect_at(0, S_M1, 1, "rst_m1");      expect_at(0, S_HALT, 1, "rst_halt");
    expect_at(0, S_DI, 0, "rst_di");      expect_at(0, S_INT, 0, "rst_int");
    expect_at(0, S_WAIT, 0, "rst_wait");  expect_at(0, S_PEND, 0, "rst_pend");
    step(1);
    RESET = 1'b1;
    expect_at(3, S_PEND, 0, "no_false_nmi");

    // address + strobes, 1-cycle latency
    CORE_ADDR = 16'h1234; CORE_MREQ = 1'b1; CORE_M1 = 1'b1;
    expect_at(1, S_ADDR, 32'h1234, "addr"); expect_at(1, S_MREQ, 0, "mreq_on");
    expect_at(1, S_M1, 0, "m1_on");         expect_at(1, S_WR, 1, "wr_idle");
    step(1);
    CORE_MREQ = 1'b0; CORE_M1 = 1'b0; CORE_IORQ = 1'b1; CORE_HALT = 1'b1;
    CORE_ADDR = 16'hBEEF;
    expect_at(1, S_MREQ, 1, "mreq_off");    expect_at(1, S_IORQ, 0, "iorq_on");
    expect_at(1, S_HALT, 0, "halt_on");     expect_at(1, S_ADDR, 32'hBEEF, "addr2");
    step(1);
    CORE_IORQ = 1'b0; CORE_HALT = 1'b0;
    expect_at(1, S_IORQ, 1, "iorq_off");    expect_at(1, S_HALT, 1, "halt_off");

    // read capture while not driving
    DI_PAD = 8'hA5;
    expect_at(1, S_DI, 32'hA5, "di_cap");
    step(2);

    // write window: WR high 3, low 1, high 2, then low
    CORE_WR = 1'b1; CORE_DO = 8'h5A;
    expect_at(1, S_DOE, 1, "doe_k1"); expect_at(2, S_DOE, 1, "doe_k2");
    expect_at(3, S_DOE, 1, "doe_k3"); expect_at(4, S_DOE, 0, "doe_k4");
    expect_at(5, S_DOE, 0, "doe_gap"); expect_at(6, S_DOE, 1, "doe_k6");
    expect_at(7, S_DOE, 0, "doe_k7");
    expect_at(1, S_WR, 0, "wr_k1");   expect_at(4, S_WR, 1, "wr_k4");
    expect_at(5, S_WR, 0, "wr_k5");
    expect_at(1, S_DO, 32'h5A, "do_k1"); expect_at(2, S_DO, 32'h77, "do_k2");
    expect_at(2, S_DI, 32'hA5, "di_hold2"); expect_at(3, S_DI, 32'hA5, "di_hold3");
    expect_at(4, S_DI, 32'hA5, "di_hold4"); expect_at(5, S_DI, 32'h3C, "di_recap");
    step(1);
    DI_PAD = 8'h3C; CORE_DO = 8'h77;
    step(2);
    CORE_WR = 1'b0;
    step(1);
    CORE_WR = 1'b1;
    step(2);
    CORE_WR = 1'b0;
    step(3);

    // INT/WAIT synchroniser latency
    INT_PAD = 1'b0; WAIT_PAD = 1'b0;
    expect_at(1, S_INT, 0, "int_k1");   expect_at(2, S_INT, 1, "int_k2");
    expect_at(1, S_WAIT, 0, "wait_k1"); expect_at(2, S_WAIT, 1, "wait_k2");
    step(3);
    INT_PAD = 1'b1; WAIT_PAD = 1'b1;
    expect_at(1, S_INT, 1, "int_rel1"); expect_at(2, S_INT, 0, "int_rel2");
    expect_at(2, S_WAIT, 0, "wait_rel2");
    step(4);

    // short NMI glitch is filtered out
    NMI_PAD = 1'b0;
    for (int k = 1; k <= 8; k++) expect_at(k, S_PEND, 0, "nmi_glitch");
    step(1);
    NMI_PAD = 1'b1;
    step(8);

    // long NMI: pend at SYNC+FILTER+1, ack clears, no re-set while low
    NMI_PAD = 1'b0;
    expect_at(4, S_PEND, 0, "nmi_k4"); expect_at(5, S_PEND, 1, "nmi_k5");
    expect_at(6, S_PEND, 1, "nmi_k6"); expect_at(7, S_PEND, 0, "nmi_ack");
    for (int k = 8; k <= 14; k++) expect_at(k, S_PEND, 0, "nmi_once");
    step(6);
    CORE_NMI_ACK = 1'b1;
    step(1);
    CORE_NMI_ACK = 1'b0;
    step(3);
    NMI_PAD = 1'b1;
    step(6);

    // ack collides with a second accept: pend must stay set
    NMI_PAD = 1'b0;
    expect_at(5, S_PEND, 1, "first_pend");
    step(6);
    NMI_PAD = 1'b1;
    step(4);
    NMI_PAD = 1'b0;
    expect_at(4, S_PEND, 1, "coll_k4"); expect_at(5, S_PEND, 1, "coll_ack");
    expect_at(6, S_PEND, 1, "coll_k6"); expect_at(8, S_PEND, 0, "coll_clr");
    step(4);
    CORE_NMI_ACK = 1'b1;
    step(1);
    CORE_NMI_ACK = 1'b0;
    step(2);
    CORE_NMI_ACK = 1'b1;
    step(1);
    CORE_NMI_ACK = 1'b0;
    NMI_PAD = 1'b1;
    step(4);

    // asynchronous reset mid-write
    CORE_WR = 1'b1; CORE_ADDR = 16'h4321;
    expect_at(1, S_DOE, 1, "mid_doe_on");
    step(2);
    RESET = 1'b0;
    expect_at(0, S_DOE, 0, "mid_rst_doe"); expect_at(0, S_WR, 1, "mid_rst_wr");
    expect_at(0, S_ADDR, 0, "mid_rst_addr");
    step(1);
    CORE_WR = 1'b0;
    RESET = 1'b1;
    step(3);

    if (sb.size() != 0) begin
      foreach (sb[i]) begin
        errors++;
        $display("FAIL %s never checked (due cyc=%0d)", sb[i].name, sb[i].cyc);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
